// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types for the multiply/divide unit.
//   mdu_op_e    - 4-bit operation code carried on req_op
//   mdu_state_e - sequencing state of mdu_unit
//   MDU_OP_W    - width of the operation code
//   op_is_signed - true for the signed multiply-class ops
package mdu_pkg;

  localparam int MDU_OP_W = 4;

  // Codes 10..15 are left unnamed; they are accepted as illegal no-ops.
  typedef enum logic [MDU_OP_W-1:0] {
    OP_MUL   = 4'd0,
    OP_MULU  = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  function automatic logic op_is_signed(mdu_op_e op);
    return (op == OP_MUL) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// mdu_div_iter: restoring divider datapath, one quotient bit per step.
// Works on unsigned magnitudes only; sign handling lives in mdu_unit.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start       - load dividend/divisor and arm the iteration counter
//   step        - perform one restoring step
//   dividend    - magnitude of the dividend (sampled on start)
//   divisor     - magnitude of the divisor (sampled on start)
//   quotient    - magnitude quotient (valid after XLEN steps)
//   remainder   - magnitude remainder (valid after XLEN steps)
//   last        - counter is at 0: the current step is the final one
module mdu_div_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);

  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;   // holds the unconsumed dividend bits, then the quotient
  logic [XLEN-1:0]  dvs_q;
  logic [CNT_W-1:0] cnt_q;

  logic [XLEN:0] rem_shift;
  logic          fits;

  // Partial remainder shifted left with the next dividend bit brought in.
  // A zero divisor always "fits", giving an all-ones quotient and leaving
  // the dividend in the remainder.
  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    fits      = (rem_shift >= {1'b0, dvs_q});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= CNT_W'(XLEN - 1);
    end else if (step) begin
      if (fits) rem_q <= XLEN'(rem_shift - {1'b0, dvs_q});
      else      rem_q <= rem_shift[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], fits};
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign last      = (cnt_q == '0);

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multiply/divide unit owning the architectural HI/LO pair.
// One operation at a time; products take one cycle in ST_MUL, quotients
// take XLEN cycles in ST_DIV plus a sign-fix cycle in ST_FIX.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU
// (accumulate into {hi,lo}); without it those codes are illegal no-ops.
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high and cancel is low; req_ready is high only in
// ST_IDLE, and op/operands are captured on that edge.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   req_valid/req_ready - request handshake
//   req_op              - mdu_op_e operation code
//   req_src1, req_src2  - rs / rt operands
//   cancel              - flush: abort the in-flight op, drop any request
//   busy                - an operation is in flight (state != IDLE)
//   done                - registered one-cycle completion pulse
//   hi, lo              - HI/LO registers
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [MDU_OP_W-1:0] req_op,
  input  logic [XLEN-1:0]     req_src1,
  input  logic [XLEN-1:0]     req_src2,
  input  logic                cancel,
  output logic                busy,
  output logic                done,
  output logic [XLEN-1:0]     hi,
  output logic [XLEN-1:0]     lo
);

  mdu_state_e state_q, state_d;
  mdu_op_e    op_q;
  mdu_op_e    req_op_e;
  logic [XLEN-1:0] src1_q, src2_q;

  logic            accept;
  logic            hi_we, lo_we, done_d;
  logic [XLEN-1:0] hi_d, lo_d;

  logic              div_start, div_step, div_last;
  logic [XLEN-1:0]   div_dividend, div_divisor;
  logic [XLEN-1:0]   div_quo, div_rem;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  logic [2*XLEN-1:0] ext1, ext2, product, mul_result;

  assign req_op_e  = mdu_op_e'(req_op);
  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = req_valid && req_ready && !cancel;

  // Divider is fed magnitudes straight from the request so the first
  // restoring step can run in the first ST_DIV cycle.
  always_comb begin
    div_dividend = req_src1;
    div_divisor  = req_src2;
    if (req_op_e == OP_DIV) begin
      if (req_src1[XLEN-1]) div_dividend = -req_src1;
      if (req_src2[XLEN-1]) div_divisor  = -req_src2;
    end
  end

  mdu_div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .step      (div_step),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_quo),
    .remainder (div_rem),
    .last      (div_last)
  );

  // Sign fix-up for signed division from the captured operand signs.
  always_comb begin
    quo_fix = div_quo;
    rem_fix = div_rem;
    if (op_q == OP_DIV) begin
      if (src1_q[XLEN-1] ^ src2_q[XLEN-1]) quo_fix = -div_quo;
      if (src1_q[XLEN-1])                  rem_fix = -div_rem;
    end
  end

  // Full-width product: extending both operands to 2*XLEN makes the
  // truncated product correct for both signed and unsigned forms.
  always_comb begin
    if (op_is_signed(op_q)) begin
      ext1 = {{XLEN{src1_q[XLEN-1]}}, src1_q};
      ext2 = {{XLEN{src2_q[XLEN-1]}}, src2_q};
    end else begin
      ext1 = {{XLEN{1'b0}}, src1_q};
      ext2 = {{XLEN{1'b0}}, src2_q};
    end
    product    = ext1 * ext2;
    mul_result = product;
`ifdef MDU_MADD_EN
    case (op_q)
      OP_MADD, OP_MADDU: mul_result = {hi, lo} + product;
      OP_MSUB, OP_MSUBU: mul_result = {hi, lo} - product;
      default:           mul_result = product;
    endcase
`endif
  end

  always_comb begin
    state_d   = state_q;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    hi_d      = hi;
    lo_d      = lo;
    done_d    = 1'b0;
    div_start = 1'b0;
    div_step  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (req_op_e)
            OP_MUL, OP_MULU: state_d = ST_MUL;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: state_d = ST_MUL;
`endif
            OP_DIV, OP_DIVU: begin
              state_d   = ST_DIV;
              div_start = 1'b1;
            end
            OP_MTHI: begin
              hi_we  = 1'b1;
              hi_d   = req_src1;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_we  = 1'b1;
              lo_d   = req_src1;
              done_d = 1'b1;
            end
            // Illegal codes complete immediately without touching HI/LO.
            default: done_d = 1'b1;
          endcase
        end
      end
      ST_MUL: begin
        state_d      = ST_IDLE;
        hi_we        = 1'b1;
        lo_we        = 1'b1;
        {hi_d, lo_d} = mul_result;
        done_d       = 1'b1;
      end
      ST_DIV: begin
        div_step = 1'b1;
        if (div_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        hi_we   = 1'b1;
        lo_we   = 1'b1;
        hi_d    = rem_fix;
        lo_d    = quo_fix;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush overrides everything: no write, no completion, back to idle.
    if (cancel) begin
      state_d   = ST_IDLE;
      hi_we     = 1'b0;
      lo_we     = 1'b0;
      done_d    = 1'b0;
      div_start = 1'b0;
      div_step  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_MUL;
      src1_q  <= '0;
      src2_q  <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      if (accept) begin
        op_q   <= req_op_e;
        src1_q <= req_src1;
        src2_q <= req_src2;
      end
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed and randomized checks of mdu_unit against an
// arithmetic reference model of HI/LO and completion latency.
module tb_mdu_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [3:0]      req_op;
  logic [XLEN-1:0] req_src1;
  logic [XLEN-1:0] req_src2;
  logic            cancel;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_hi, m_lo;

  mdu_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_src1  (req_src1),
    .req_src2  (req_src2),
    .cancel    (cancel),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Updates m_hi/m_lo with the architectural effect of one op and returns
  // the expected accept-to-done latency in cycles.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    longint      x, y;
    logic [63:0] p, acc;
    int          sa, sb;
    lat = 1;
    if (op == 4'd0 || op == 4'd6 || op == 4'd8) begin
      x = $signed(a);
      y = $signed(b);
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    p = 64'(x * y);
    case (op)
      4'd0, 4'd1: begin
        {m_hi, m_lo} = p;
        lat = 2;
      end
      4'd6, 4'd7, 4'd8, 4'd9: begin
`ifdef MDU_MADD_EN
        acc = {m_hi, m_lo};
        acc = (op < 4'd8) ? acc + p : acc - p;
        {m_hi, m_lo} = acc;
        lat = 2;
`else
        acc = p;
`endif
      end
      4'd2: begin
        lat = XLEN + 2;
        if (b == 32'd0) begin
          m_lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
          m_hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 32'd0;
        end else begin
          sa = $signed(a);
          sb = $signed(b);
          m_lo = 32'(sa / sb);
          m_hi = 32'(sa % sb);
        end
      end
      4'd3: begin
        lat = XLEN + 2;
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      4'd4: m_hi = a;
      4'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int   lat, exp_lat;
    logic bad_ready;
    model(op, a, b, exp_lat);
    @(negedge clk);
    check("ready_before", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat       = 1;
    bad_ready = 1'b0;
    while (done !== 1'b1 && lat < 200) begin
      if (req_ready !== 1'b0 || busy !== 1'b1) bad_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency op%0d", op), lat, exp_lat);
    check($sformatf("ready_busy op%0d", op), bad_ready, 0);
    check($sformatf("hi op%0d", op), hi, m_hi);
    check($sformatf("lo op%0d", op), lo, m_lo);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    logic [3:0] op;
    logic [31:0] a, b;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 4'd0;
    req_src1  = '0;
    req_src2  = '0;
    cancel    = 1'b0;
    m_hi      = '0;
    m_lo      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    check("reset_ready", req_ready, 1);
    reset = 1'b0;

    // Multiply, signed and unsigned
    run_op(4'd0, 32'hFFFF_FFFE, 32'd3);
    check("mul_hi_const", hi, 32'hFFFF_FFFF);
    check("mul_lo_const", lo, 32'hFFFF_FFFA);
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3);
    check("mulu_hi_const", hi, 32'd2);
    check("mulu_lo_const", lo, 32'hFFFF_FFFA);

    // Division, including divide-by-zero and overflow corners
    run_op(4'd2, 32'hFFFF_FFF9, 32'd2);
    check("div_lo_const", lo, 32'hFFFF_FFFD);
    check("div_hi_const", hi, 32'hFFFF_FFFF);
    run_op(4'd3, 32'd100, 32'd7);
    check("divu_lo_const", lo, 32'd14);
    check("divu_hi_const", hi, 32'd2);
    run_op(4'd3, 32'd7, 32'd0);
    check("divu0_lo_const", lo, 32'hFFFF_FFFF);
    check("divu0_hi_const", hi, 32'd7);
    run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    check("divovf_lo_const", lo, 32'h8000_0000);
    check("divovf_hi_const", hi, 32'd0);
    run_op(4'd2, 32'hFFFF_FFF9, 32'd0);
    check("div0_lo_const", lo, 32'd1);
    check("div0_hi_const", hi, 32'hFFFF_FFF9);

    // Cancel in the middle of a division
    run_op(4'd4, 32'h11, 32'd0);
    run_op(4'd5, 32'h11, 32'd0);
    pulses = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 4'd3;
    req_src1  = 32'd100;
    req_src2  = 32'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    cancel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_ready", req_ready, 1);
    check("cancel_busy", busy, 0);
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("cancel_no_done", pulses, 0);
    check("cancel_hi", hi, 32'h11);
    check("cancel_lo", lo, 32'h11);

    // MTHI, MTLO back to back, then a MUL dropped by cancel
    pulses = 0;
    req_valid = 1'b1;
    req_op    = 4'd4;
    req_src1  = 32'hA5;
    req_src2  = 32'd0;
    @(posedge clk);
    @(negedge clk);
    if (done === 1'b1) pulses++;
    req_op   = 4'd5;
    req_src1 = 32'h5A;
    @(posedge clk);
    @(negedge clk);
    if (done === 1'b1) pulses++;
    req_op   = 4'd0;
    req_src1 = 32'd3;
    req_src2 = 32'd3;
    cancel   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cancel    = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    m_hi = 32'hA5;
    m_lo = 32'h5A;
    check("mt_pulses", pulses, 2);
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
    check("mt_ready", req_ready, 1);

    // Accumulate (or illegal no-op when the feature is absent)
    run_op(4'd4, 32'd0, 32'd0);
    run_op(4'd5, 32'hFFFF_FFFF, 32'd0);
    run_op(4'd7, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    check("maddu_hi_const", hi, 32'd1);
    check("maddu_lo_const", lo, 32'd0);
`else
    check("maddu_hi_const", hi, 32'd0);
    check("maddu_lo_const", lo, 32'hFFFF_FFFF);
`endif

    // Randomized operations against the model
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = rnd_operand();
      b  = rnd_operand();
      run_op(op, a, b);
    end

    // Reset in the middle of a division
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 4'd2;
    req_src1  = $urandom;
    req_src2  = 32'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    check("rst_mid_hi", hi, m_hi);
    check("rst_mid_lo", lo, m_lo);
    check("rst_mid_ready", req_ready, 1);
    check("rst_mid_busy", busy, 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("rst_mid_no_done", pulses, 0);
    run_op(4'd3, 32'd100, 32'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Parametrised multiply/divide unit holding the architectural HI/LO pair, replacing the EXE stage's inline multiplier, vendor divider IP and HI/LO registers. Accepts one operation at a time over a valid/ready handshake, computes products in one cycle and quotients with an iterative one-bit-per-cycle restoring divider. Supports flushing on exceptions. EXE stalls on `req_ready`/`busy` and reads `hi`/`lo` for MFHI/MFLO.

## Interface
Parameters:
- `XLEN`, default 32: operand and HI/LO width. Must be even and at least 8.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle and able to accept.
- `req_op`  in  4  operation code (`mdu_pkg` encoding).
- `req_src1`  in  XLEN  rs value: dividend, multiplicand, or MTHI/MTLO data.
- `req_src2`  in  XLEN  rt value: divisor or multiplier.
- `cancel`  in  1  flush: abort any in-flight operation.
- `busy`  out  1  multi-cycle operation in flight.
- `done`  out  1  one-cycle pulse; `hi`/`lo` already hold the result.
- `hi`  out  XLEN  HI register.
- `lo`  out  XLEN  LO register.

## Operation
Op codes:
- MUL=0, MULU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
- MADD=6, MADDU=7, MSUB=8, MSUBU=9.
- Codes 10–15 are illegal.

Acceptance:
- A request is accepted when `req_valid && req_ready`.
- Operands and op are latched at that edge.
- `req_ready = (state==IDLE)`.
- `busy = (state!=IDLE)`.

States:
- IDLE
  - MUL/MULU/MADD*/MSUB* → MUL.
  - DIV/DIVU → DIV.
  - MTHI/MTLO write `hi`/`lo` at the accept edge and stay in IDLE.
  - Illegal ops are accepted, leave HI/LO unchanged and stay in IDLE.
- MUL (1 cycle)
  - Multiply latched operands: signed for MUL/MADD/MSUB, unsigned otherwise.
  - Form the 2·XLEN-bit product and write {hi,lo} → IDLE.
- DIV (XLEN cycles)
  - Operate on magnitudes: for DIV, take two's-complement absolute values of the operands; DIVU uses operands raw.
  - Run XLEN restoring steps, counter counting XLEN-1 down to 0.
  - Counter is `$clog2(XLEN)` bits → FIX.
- FIX (1 cycle)
  - Quotient is negated if sign(src1)^sign(src2) and op is DIV.
  - Remainder is negated if sign(src1) and op is DIV.
  - Write lo=quotient, hi=remainder → IDLE.

Arithmetic rules:
- All results wrap modulo 2^XLEN; the accumulate wraps modulo 2^(2·XLEN).
- Divide by zero raises no exception. The magnitude quotient is all-ones and the magnitude remainder is |dividend|, then FIX applies.
  - DIVU 7/0 → lo=FFFFFFFF, hi=7.
  - DIV -7/0 → lo=1, hi=-7.
- DIV 0x80000000 / -1 → lo=0x80000000, hi=0.

`done`:
- Registered; high for exactly one cycle after any accepted operation finishes, including MTHI/MTLO and illegal ops.

Cancel:
- `cancel` high forces state→IDLE at the next edge.
- No HI/LO write and no `done` for the aborted operation.
- A `req_valid` in the same cycle is dropped (cancel wins).
- A MUL/FIX-cycle write coinciding with `cancel` is suppressed.

Reset:
- state=IDLE, hi=0, lo=0, done=0, busy=0, req_ready=1.
- Reset mid-division discards all progress.

## Timing
- Accept at edge E0.
- MTHI/MTLO/illegal: HI/LO visible and `done`=1 in cycle E0+1. `req_ready` stays 1, so back-to-back accepts are allowed.
- MUL class: MUL state in cycle E0+1, write at E1, `done`=1 in cycle E0+2. Accept-to-done is 2 cycles.
- DIV class: DIV cycles E0+1..E0+XLEN, FIX in cycle E0+XLEN+1, `done` in cycle E0+XLEN+2 (34 cycles at XLEN=32).
- The earliest next accept is the cycle `done` is high.
- `hi`/`lo` are register outputs only; there is no combinational bypass.

## Configuration
`MDU_MADD_EN`:
- Defined: ops 6–9 compute {hi,lo} ← {hi,lo} ± product in the MUL cycle. Signedness is as for MUL; latency is unchanged.
- Undefined: ops 6–9 behave as illegal codes, and no 2·XLEN adder is built.

## Structure
Package `mdu_pkg` contains:
- `mdu_op_e` (4-bit op enum).
- `mdu_state_e` (IDLE, MUL, DIV, FIX).
- `MDU_OP_W=4`.

Sub-module `mdu_div_iter`:
- Restoring divider datapath with start/step inputs and an XLEN iteration counter.
- Outputs magnitude quotient and remainder.
- Sign handling and the FSM stay in `mdu_unit`.

## Test plan
- MUL 0xFFFFFFFE × 3 → hi=FFFFFFFF, lo=FFFFFFFA. MULU with the same operands → hi=2, lo=FFFFFFFA. `done` arrives 2 cycles after accept.
- DIV -7 / 2 → lo=FFFFFFFD, hi=FFFFFFFF. DIVU 100/7 → lo=14, hi=2. `done` arrives XLEN+2 cycles after accept; `req_ready`=0 throughout.
- DIVU 7/0 → lo=FFFFFFFF, hi=7. DIV 0x80000000/-1 → lo=80000000, hi=0.
- Start DIV 100/7 with hi=lo=0x11, then pulse `cancel` in cycle 10 → no `done`, hi=lo=0x11 unchanged, `req_ready`=1 the next cycle.
- MTHI 0xA5, then MTLO 0x5A on the following cycle, then MUL with `cancel` on its accept cycle → hi=A5, lo=5A, exactly two `done` pulses.
- With `MDU_MADD_EN`: hi=0, lo=FFFFFFFF, MADDU 1×1 → hi=1, lo=0. Without the macro, the same request leaves hi=0, lo=FFFFFFFF and still pulses `done`.
